// File: rtl/pe_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkt_pkg
// Brief    : Packet layout, packet types, FSM encodings and LOAD packer.
// Revision : 1.0  initial release
// ============================================================================
package pe_pkt_pkg;

    localparam int PKT_W   = 39;
    localparam int BYTE_W  = 8;
    localparam int N_TAPS  = 3;
    localparam int N_IFMAP = 5;
    localparam int DEST_W  = 8;

    localparam logic [1:0] PKT_LOAD = 2'b01;
    localparam logic [1:0] PKT_PSUM = 2'b10;

    localparam int TYPE_HI  = 38;
    localparam int TYPE_LO  = 37;
    localparam int DEST_HI  = 36;
    localparam int DEST_LO  = 29;
    localparam int IFMAP_HI = 28;
    localparam int ROW_HI   = 27;
    localparam int ROW_LO   = 26;
    localparam int COL_HI   = 25;
    localparam int COL_LO   = 24;
    localparam int FILT_HI  = 23;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // ifmap0 lands in the MSB of its field; filter0 in the highest byte.
    function automatic logic [PKT_W-1:0] pack_load(
        input logic [DEST_W-1:0]        dest,
        input logic [N_IFMAP-1:0]       ifmap,
        input logic [N_TAPS*BYTE_W-1:0] filter
    );
        logic [PKT_W-1:0] p;
        p = '0;
        p[TYPE_HI:TYPE_LO] = PKT_LOAD;
        p[DEST_HI:DEST_LO] = dest;
        for (int k = 0; k < N_IFMAP; k++) begin
            p[IFMAP_HI-k] = ifmap[k];
        end
        for (int k = 0; k < N_TAPS; k++) begin
            p[FILT_HI-k*BYTE_W -: BYTE_W] = filter[k*BYTE_W +: BYTE_W];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_psum_collector.sv
`default_nettype none
// ============================================================================
// Module   : pe_psum_collector
// Brief    : Decodes returning PSUM packets, filters bad ones, stores by col.
// Revision : 1.0  initial release
// ============================================================================
module pe_psum_collector
    import pe_pkt_pkg::*;
#(
    parameter int WIDTH   = 39,
    parameter int WIDTH_F = 8,
    parameter int DEPTH_F = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 exp_row,
    output logic                       last_accept,
    output logic                       err,
    output logic [DEPTH_F*WIDTH_F-1:0] psum
);

    localparam int               CNT_W    = $clog2(DEPTH_F + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH_F - 1);

    logic [1:0]                 w_type;
    logic [1:0]                 w_row;
    logic [1:0]                 w_col;
    logic [1:0]                 w_idx;
    logic                       w_hs;
    logic                       w_col_ok;
    logic                       w_seen;
    logic                       w_good;
    logic                       w_unused;
    logic [DEPTH_F-1:0]         r_mask;
    logic [CNT_W-1:0]           r_count;
    logic [DEPTH_F*WIDTH_F-1:0] r_psum;
    logic                       r_err;

    always_comb begin
        w_type   = in_data[TYPE_HI:TYPE_LO];
        w_row    = in_data[ROW_HI:ROW_LO];
        w_col    = in_data[COL_HI:COL_LO];
        w_hs     = enable & in_valid;
        w_col_ok = (w_col != 2'd0) && (int'(w_col) <= DEPTH_F);
        w_idx    = w_col - 2'd1;
        // An out-of-range col reads as already seen so it is always dropped.
        w_seen   = 1'b1;
        for (int k = 0; k < DEPTH_F; k++) begin
            if (w_col_ok && (w_idx == 2'(k))) begin
                w_seen = r_mask[k];
            end
        end
        w_good   = (w_type == PKT_PSUM) && (w_row == exp_row) && w_col_ok && !w_seen;
    end

    assign w_unused = ^{in_data[DEST_HI:DEST_LO], in_data[IFMAP_HI], in_data[FILT_HI:WIDTH_F]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '0;
            r_count <= '0;
            r_psum  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_hs & ~w_good;
            if (clear) begin
                r_mask  <= '0;
                r_count <= '0;
            end else if (w_hs && w_good) begin
                r_count <= r_count + CNT_W'(1);
                for (int k = 0; k < DEPTH_F; k++) begin
                    if (w_idx == 2'(k)) begin
                        r_mask[k]                  <= 1'b1;
                        r_psum[k*WIDTH_F +: WIDTH_F] <= in_data[WIDTH_F-1:0];
                    end
                end
            end
        end
    end

    assign last_accept = w_hs & w_good & (r_count == LAST_CNT);
    assign err         = r_err;
    assign psum        = r_psum;

endmodule
`default_nettype wire

// File: rtl/pe_pkt_master.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkt_master
// Brief    : NoC initiator for one PE: sends a LOAD packet, gathers its psums.
// Revision : 1.0  initial release
// ============================================================================
module pe_pkt_master
    import pe_pkt_pkg::*;
#(
    parameter int WIDTH   = 39,
    parameter int WIDTH_F = 8,
    parameter int DEPTH_F = 3,
    parameter int DEPTH_I = 5,
    parameter int ADDR_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [ADDR_W-1:0]          cfg_dest,
    input  logic [1:0]                 cfg_row,
    input  logic [DEPTH_F*WIDTH_F-1:0] cfg_filter,
    input  logic [DEPTH_I-1:0]         cfg_ifmap,
    output logic                       pkt_out_valid,
    input  logic                       pkt_out_ready,
    output logic [WIDTH-1:0]           pkt_out_data,
    input  logic                       pkt_in_valid,
    output logic                       pkt_in_ready,
    input  logic [WIDTH-1:0]           pkt_in_data,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DEPTH_F*WIDTH_F-1:0] res_psum,
    output logic                       err
);

    logic [1:0]       r_state;
    logic [1:0]       r_row;
    logic [WIDTH-1:0] r_pkt;
    logic             w_last;
    logic             w_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_pkt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_pkt   <= pack_load(cfg_dest, cfg_ifmap, cfg_filter);
                        r_row   <= cfg_row;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND:    if (pkt_out_ready) r_state <= ST_COLLECT;
                ST_COLLECT: if (w_last)        r_state <= ST_DONE;
                ST_DONE:    if (res_ready)     r_state <= ST_IDLE;
                default:                       r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready     = (r_state == ST_IDLE);
    assign pkt_out_valid = (r_state == ST_SEND);
    assign pkt_out_data  = r_pkt;
    assign pkt_in_ready  = (r_state == ST_COLLECT);
    assign res_valid     = (r_state == ST_DONE);
    assign w_clear       = res_valid & res_ready;

    pe_psum_collector #(
        .WIDTH   (WIDTH),
        .WIDTH_F (WIDTH_F),
        .DEPTH_F (DEPTH_F)
    ) u_collector (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_clear),
        .enable      (pkt_in_ready),
        .in_valid    (pkt_in_valid),
        .in_data     (pkt_in_data),
        .exp_row     (r_row),
        .last_accept (w_last),
        .err         (err),
        .psum        (res_psum)
    );

endmodule
`default_nettype wire
